spi_slave_if: RTL and testbench

- Serial front end of the SPI-slave/RAM subsystem; sits directly upstream of the single-port RAM.
- Deserialises MOSI into 10-bit command words and presents each word with a one-cycle rx_valid strobe.
- On a read-data command, waits for the RAM's tx_valid/tx_data response and serialises the 8-bit byte back MSB-first on MISO.
- SPI bit clock is the system clock clk; MOSI and SS_n arrive already synchronous to clk.

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/spi_shift_ctr.sv | 40 ++++
 rtl/spi_slave_if.sv | 120 ++++++++++++
 tb/tb_spi_slave_if.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-slave/RAM subsystem: word widths, command codes
// and the serial front end's state and read sub-phase encodings.
package spi_ram_pkg;

  localparam int WORD_W = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX,
    PH_DONE
  } phase_e;

endpackage

// File: rtl/spi_shift_ctr.sv
// Loadable MSB-first shift register paired with a down-counter of remaining shifts.
// done is high once the counter has reached zero; clear only resets the counter.
module spi_shift_ctr
  import spi_ram_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_cnt,
  input  logic          shift,
  input  logic          sin,
  output logic [W-1:0]  data,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= load_cnt;
    end else if (shift) begin
      data <= {data[W-2:0], sin};
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: collects 10-bit command words from MOSI for the RAM and,
// for read-data commands, returns the RAM byte MSB-first on MISO.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int WORD_W = spi_ram_pkg::WORD_W,
  parameter int DATA_W = spi_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int RX_CW = $clog2(WORD_W);
  localparam int TX_CW = $clog2(DATA_W);

  state_e            state;
  phase_e            phase;
  logic              addr_held;
  logic [WORD_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic              rx_done, tx_done;
  logic              in_word, abort;
  logic              rx_load, rx_shift, tx_load, tx_shift;
  logic              unused_bits;

  assign abort    = SS_n && (state != IDLE);
  assign in_word  = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign rx_load  = (state == CHK_CMD) && !SS_n;
  assign rx_shift = in_word && (phase == PH_RX) && !SS_n && !rx_done;
  // A tx_valid seen while our own strobe is still up is the RAM's previous level.
  assign tx_load  = (state == READ_DATA) && (phase == PH_WAIT) && tx_valid && !rx_valid && !SS_n;
  assign tx_shift = (state == READ_DATA) && (phase == PH_TX) && !SS_n && !tx_done;
  assign MISO     = ((state == READ_DATA) && (phase == PH_TX)) ? tx_q[DATA_W-1] : 1'b0;

  // The word's MSB is recovered from the final concatenation, the tx low bits only feed the shift chain.
  assign unused_bits = ^{rx_q[WORD_W-1], tx_q[DATA_W-2:0]};

  spi_shift_ctr #(.W(WORD_W)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (rx_load),
    .load_data ({{(WORD_W-1){1'b0}}, MOSI}),
    .load_cnt  (RX_CW'(WORD_W-2)),
    .shift     (rx_shift),
    .sin       (MOSI),
    .data      (rx_q),
    .done      (rx_done)
  );

  spi_shift_ctr #(.W(DATA_W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (tx_load),
    .load_data (tx_data),
    .load_cnt  (TX_CW'(DATA_W-1)),
    .shift     (tx_shift),
    .sin       (1'b0),
    .data      (tx_q),
    .done      (tx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= PH_RX;
      addr_held <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
        phase <= PH_RX;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            phase <= PH_RX;
            if (!MOSI)           state <= WRITE;
            else if (!addr_held) state <= READ_ADD;
            else                 state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            case (phase)
              PH_RX: begin
                if (rx_done) begin
                  rx_data  <= {rx_q[WORD_W-2:0], MOSI};
                  rx_valid <= 1'b1;
                  if (state == READ_DATA) begin
                    phase     <= PH_WAIT;
                    addr_held <= 1'b0;
                  end else begin
                    phase <= PH_DONE;
                    if (state == READ_ADD) addr_held <= 1'b1;
                  end
                end
              end
              PH_WAIT: if (tx_load) phase <= PH_TX;
              PH_TX:   if (tx_done) phase <= PH_DONE;
              default: phase <= PH_DONE;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if with a registered RAM model on
// the tx side and a frame-level reference model of the command protocol.
module tb_spi_slave_if;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       MOSI = 1'b0;
  logic       SS_n = 1'b1;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  int tests = 0;
  int fails = 0;
  int stray = 0;
  bit in_window = 0;

  typedef struct {
    logic [9:0] word;
    bit         rd;
    logic [7:0] data;
  } exp_t;
  exp_t rx_exp[$];

  // Registered RAM: answers a read-data command one edge after the strobe.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wr_addr = 8'h00;
  logic [7:0] ram_rd_addr = 8'h00;
  logic [7:0] ram_tx_data = 8'h00;
  logic       ram_tx_valid = 1'b0;
  logic       stale_force = 1'b0;
  logic [7:0] stale_data = 8'h00;

  assign tx_valid = ram_tx_valid | stale_force;
  assign tx_data  = ram_tx_valid ? ram_tx_data : stale_data;

  always @(posedge clk or posedge rst) begin
    if (rst) ram_tx_valid <= 1'b0;
    else if (rx_valid) begin
      case (rx_data[9:8])
        CMD_WR_ADDR: begin ram_wr_addr <= rx_data[7:0]; ram_tx_valid <= 1'b0; end
        CMD_WR_DATA: begin ram_mem[ram_wr_addr] <= rx_data[7:0]; ram_tx_valid <= 1'b0; end
        CMD_RD_ADDR: begin ram_rd_addr <= rx_data[7:0]; ram_tx_valid <= 1'b0; end
        default:     begin ram_tx_data <= ram_mem[ram_rd_addr]; ram_tx_valid <= 1'b1; end
      endcase
    end
  end

  // Reference model of what a complete frame should achieve.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr_addr = 8'h00;
  logic [7:0] ref_rd_addr = 8'h00;
  bit         ref_held = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_frame(input logic [9:0] w, output bit rd, output logic [7:0] b);
    rd = 0;
    b  = 8'h00;
    if (!w[9]) begin
      if (!w[8]) ref_wr_addr = w[7:0];
      else       ref_mem[ref_wr_addr] = w[7:0];
    end else if (!ref_held) begin
      ref_held    = 1;
      ref_rd_addr = w[7:0];
    end else begin
      ref_held = 0;
      rd       = 1;
      b        = ref_mem[ref_rd_addr];
    end
    rx_exp.push_back('{w, rd, b});
  endtask

  // nbits<10 aborts after that many bits; abort_b0 raises SS_n with bit 0;
  // stale holds tx_valid high with a wrong byte; rst_at pulses rst in the tail.
  task automatic apply_stimulus(input logic [9:0] w, input int nbits, input bit abort_b0,
                                input bit stale, input int rst_at);
    bit         rd;
    logic [7:0] b;
    rd = 0;
    b  = 8'h00;
    if (nbits == 10 && !abort_b0) model_frame(w, rd, b);
    if (stale && rd) begin
      stale_data  = ~b;
      stale_force = 1'b1;
    end
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = w[9-i];
      if (abort_b0 && i == 9) SS_n = 1'b1;
    end
    if (nbits < 10) begin
      @(negedge clk);
      SS_n = 1'b1;
    end else if (!abort_b0) begin
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) check_output("rx_valid latency", rx_valid, 1);
        if (k == 2 && rst_at != 2) check_output("rx_valid width", rx_valid, 0);
        if (k == rst_at) begin
          #1 rst = 1'b1;
          ref_held = 0;
          #1;
          check_output("miso on rst", MISO, 0);
          check_output("rx_valid on rst", rx_valid, 0);
          check_output("rx_data on rst", rx_data, 0);
          break;
        end
      end
    end
    SS_n        = 1'b1;
    MOSI        = 1'b0;
    stale_force = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every strobe and collects MISO for reads.
  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid) begin
        if (rx_exp.size() == 0) begin
          check_output("unexpected rx_valid", rx_data, 0);
        end else begin
          e = rx_exp.pop_front();
          check_output("rx_data", rx_data, e.word);
          if (e.rd) begin
            in_window = 1;
            got       = 8'h00;
            aborted   = 0;
            for (int j = 0; j < 10; j++) begin
              @(negedge clk);
              if (rst) begin
                aborted = 1;
                break;
              end
              if (j == 0)      check_output("miso before byte", MISO, 0);
              else if (j == 9) check_output("miso after byte", MISO, 0);
              else             got = {got[6:0], MISO};
            end
            if (!aborted) check_output("miso byte", got, e.data);
            in_window = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !in_window && MISO !== 1'b0) stray++;
  end

  initial begin : main
    logic [9:0] w;
    int         r, ab;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 29 + 11);
      ref_mem[i] = 8'(i * 29 + 11);
    end
    ram_mem[7] = 8'h3C;
    ref_mem[7] = 8'h3C;

    #1 rst = 1'b1;
    #11;
    check_output("reset miso", MISO, 0);
    check_output("reset rx_valid", rx_valid, 0);
    check_output("reset rx_data", rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(10'h0A5, 10, 0, 0, 0);
    apply_stimulus(10'h207, 10, 0, 0, 0);
    apply_stimulus(10'h300, 10, 0, 0, 0);
    apply_stimulus(10'h207, 10, 0, 0, 0);
    apply_stimulus(10'h300, 10, 0, 1, 0);
    apply_stimulus(10'h0A5, 6, 0, 0, 0);
    apply_stimulus(10'h1FF, 10, 0, 0, 0);
    apply_stimulus(10'h2A5, 10, 0, 0, 0);
    apply_stimulus(10'h300, 10, 0, 0, 0);
    apply_stimulus(10'h155, 10, 1, 0, 0);
    apply_stimulus(10'h0C3, 10, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) w = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom)};
      else       w = {1'b1, ref_held, 8'($urandom)};
      ab = $urandom_range(0, 7);
      if (ab == 0)      apply_stimulus(w, $urandom_range(1, 9), 0, 0, 0);
      else if (ab == 1) apply_stimulus(w, 10, 1, 0, 0);
      else              apply_stimulus(w, 10, 0, 1'($urandom_range(0, 1)), 0);
    end

    if (ref_held) apply_stimulus(10'h300, 10, 0, 0, 0);
    apply_stimulus(10'h233, 10, 0, 0, 0);
    apply_stimulus(10'h300, 10, 0, 0, 5);
    apply_stimulus(10'h25A, 10, 0, 0, 0);
    apply_stimulus(10'h300, 10, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_output("scoreboard drained", rx_exp.size(), 0);
    check_output("stray miso cycles", stray, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
